// File: rtl/blob_point_sequencer_pkg.sv
// blob_point_sequencer_pkg
// Shared types and constants for the laser point sequencer. COORD_W and
// COLOR_W are also used by color_blob, so both blocks agree on the
// position and color widths.
//   COORD_W      : width of one position coordinate
//   COLOR_W      : width of an RGB 3:3:3 color
//   slot_desc_t  : one point descriptor (enable, x, y, color)
//   seq_state_t  : sequencer FSM states
package blob_point_sequencer_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 9;

  typedef struct packed {
    logic               enable;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } slot_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    BLANK,
    DWELL
  } seq_state_t;

endpackage

// File: rtl/blob_point_sequencer_if.sv
// blob_point_sequencer_if
// Bundles the descriptor write port, the frame sync strobe and the point
// outputs of blob_point_sequencer.
//   master : game logic side (drives writes and frame_sync, sees outputs)
//   slave  : sequencer side
interface blob_point_sequencer_if
  import blob_point_sequencer_pkg::*;
#(
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic               wr_valid;
  logic               wr_ready;
  logic [SLOT_W-1:0]  wr_slot;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               wr_enable;
  logic               frame_sync;
  logic [COORD_W-1:0] x_loc;
  logic [COORD_W-1:0] y_loc;
  logic [COLOR_W-1:0] color;
  logic               blob_en;
  logic               laser_on;
  logic [SLOT_W-1:0]  cur_slot;
  logic               round_done;

  modport master (
    output wr_valid, wr_slot, wr_x, wr_y, wr_color, wr_enable, frame_sync,
    input  wr_ready, x_loc, y_loc, color, blob_en, laser_on, cur_slot, round_done
  );

  modport slave (
    input  wr_valid, wr_slot, wr_x, wr_y, wr_color, wr_enable, frame_sync,
    output wr_ready, x_loc, y_loc, color, blob_en, laser_on, cur_slot, round_done
  );

endinterface

// File: rtl/blob_slot_bank.sv
// blob_slot_bank
// Double-buffered point descriptor storage. Writes go to the shadow bank;
// a frame_sync copies every shadow slot into the active bank in one edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_valid   : write request; wr_ready is low only during a commit cycle
//   wr_slot    : target slot (out-of-range slots are accepted and dropped)
//   wr_desc    : descriptor to store
//   frame_sync : commit strobe
//   act_en     : enable bit of every active slot
//   rd_idx     : active bank read index; rd_desc is the slot contents
module blob_slot_bank
  import blob_point_sequencer_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  slot_desc_t           wr_desc,
  input  logic                 frame_sync,
  output logic [NUM_SLOTS-1:0] act_en,
  input  logic [SLOT_W-1:0]    rd_idx,
  output slot_desc_t           rd_desc
);

  localparam logic [SLOT_W:0] SLOT_LIMIT = NUM_SLOTS[SLOT_W:0];

  slot_desc_t shadow [NUM_SLOTS];
  slot_desc_t active [NUM_SLOTS];

  // Commit owns the cycle, so the write port is refused while it happens.
  assign wr_ready = !frame_sync;

  // Commit wins over writes; a write to a slot past the end is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else if (frame_sync) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        active[i] <= shadow[i];
      end
    end else if (wr_valid && ({1'b0, wr_slot} < SLOT_LIMIT)) begin
      shadow[wr_slot] <= wr_desc;
    end
  end

  always_comb begin
    act_en = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      act_en[i] = active[i].enable;
    end
  end

  assign rd_desc = active[rd_idx];

endmodule

// File: rtl/blob_point_sequencer.sv
// blob_point_sequencer
// Time-multiplexes one laser spot over the enabled point slots. Each visit
// is one SELECT cycle, BLANK_CYCLES dark cycles for the galvos to settle,
// then DWELL_CYCLES lit cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : write port, frame_sync and registered point outputs
//                (x_loc, y_loc, color, blob_en, laser_on, cur_slot, round_done)
module blob_point_sequencer
  import blob_point_sequencer_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  blob_point_sequencer_if.slave  bus
);

  localparam int SLOT_W  = $clog2(NUM_SLOTS);
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [SLOT_W:0]   SLOT_LIMIT = NUM_SLOTS[SLOT_W:0];
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  seq_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [SLOT_W-1:0]    cur_slot_q;
  logic [COORD_W-1:0]   x_q;
  logic [COORD_W-1:0]   y_q;
  logic [COLOR_W-1:0]   color_q;
  logic                 blob_en_q;
  logic                 laser_on_q;
  logic                 round_done_q;

  slot_desc_t           wr_desc;
  slot_desc_t           rd_desc;
  logic [NUM_SLOTS-1:0] act_en;
  logic                 found;
  logic [SLOT_W-1:0]    next_idx;
  logic [SLOT_W:0]      cand_sum;
  logic [SLOT_W-1:0]    cand_idx;

  assign wr_desc = {bus.wr_enable, bus.wr_x, bus.wr_y, bus.wr_color};

  blob_slot_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (bus.wr_valid),
    .wr_ready   (bus.wr_ready),
    .wr_slot    (bus.wr_slot),
    .wr_desc    (wr_desc),
    .frame_sync (bus.frame_sync),
    .act_en     (act_en),
    .rd_idx     (next_idx),
    .rd_desc    (rd_desc)
  );

  // Round-robin search starting just after cur_slot; the last candidate is
  // cur_slot itself so a lone enabled slot keeps revisiting itself.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      cand_sum = {1'b0, cur_slot_q} + (SLOT_W+1)'(k);
      if (cand_sum >= SLOT_LIMIT) begin
        cand_sum = cand_sum - SLOT_LIMIT;
      end
      cand_idx = cand_sum[SLOT_W-1:0];
      if (!found && act_en[cand_idx]) begin
        found    = 1'b1;
        next_idx = cand_idx;
      end
    end
  end

  // Visit FSM. Outputs are registered here; a slot disabled by a commit in
  // the middle of its visit drops straight back to SELECT, dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_slot_q   <= LAST_SLOT;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      blob_en_q    <= 1'b0;
      laser_on_q   <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      round_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|act_en) begin
            state <= SELECT;
          end
        end
        SELECT: begin
          if (found) begin
            cur_slot_q   <= next_idx;
            x_q          <= rd_desc.x;
            y_q          <= rd_desc.y;
            color_q      <= rd_desc.color;
            cnt          <= BLANK_LOAD;
            round_done_q <= (next_idx <= cur_slot_q);
            state        <= BLANK;
          end else begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            state   <= IDLE;
          end
        end
        BLANK: begin
          if (!act_en[cur_slot_q]) begin
            state <= SELECT;
          end else if (cnt == '0) begin
            cnt        <= DWELL_LOAD;
            blob_en_q  <= 1'b1;
            laser_on_q <= 1'b1;
            state      <= DWELL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DWELL: begin
          if (!act_en[cur_slot_q] || (cnt == '0)) begin
            blob_en_q  <= 1'b0;
            laser_on_q <= 1'b0;
            state      <= SELECT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_loc      = x_q;
  assign bus.y_loc      = y_q;
  assign bus.color      = color_q;
  assign bus.blob_en    = blob_en_q;
  assign bus.laser_on   = laser_on_q;
  assign bus.cur_slot   = cur_slot_q;
  assign bus.round_done = round_done_q;

endmodule

// File: tb/tb_blob_point_sequencer.sv
// tb_blob_point_sequencer
// Directed bench for blob_point_sequencer with NUM_SLOTS=4, DWELL=8,
// BLANK=2, plus a 3-slot instance to exercise an out-of-range slot write.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_blob_point_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   onCount;

  blob_point_sequencer_if #(.NUM_SLOTS(4)) bus ();
  blob_point_sequencer_if #(.NUM_SLOTS(3)) bus3 ();

  blob_point_sequencer #(
    .NUM_SLOTS    (4),
    .DWELL_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  blob_point_sequencer #(
    .NUM_SLOTS    (3),
    .DWELL_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle write handshake on the 4-slot instance.
  task automatic applyStimulus(input logic [1:0] slot, input logic [9:0] x,
                               input logic [9:0] y, input logic [8:0] c,
                               input logic en);
    bus.wr_valid  = 1'b1;
    bus.wr_slot   = slot;
    bus.wr_x      = x;
    bus.wr_y      = y;
    bus.wr_color  = c;
    bus.wr_enable = en;
    @(negedge clk);
    bus.wr_valid  = 1'b0;
  endtask

  // Returns on the falling edge right after the commit edge E0.
  task automatic commitFrame();
    bus.frame_sync = 1'b1;
    @(negedge clk);
    bus.frame_sync = 1'b0;
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_slot    = '0;
    bus.wr_x       = '0;
    bus.wr_y       = '0;
    bus.wr_color   = '0;
    bus.wr_enable  = 1'b0;
    bus.frame_sync = 1'b0;
    bus3.wr_valid   = 1'b0;
    bus3.wr_slot    = '0;
    bus3.wr_x       = '0;
    bus3.wr_y       = '0;
    bus3.wr_color   = '0;
    bus3.wr_enable  = 1'b0;
    bus3.frame_sync = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset and idle
    doReset();
    waitCycles(3);
    checkOutput("rst_x_loc", 32'(bus.x_loc), 32'd0);
    checkOutput("rst_y_loc", 32'(bus.y_loc), 32'd0);
    checkOutput("rst_color", 32'(bus.color), 32'd0);
    checkOutput("rst_blob_en", 32'(bus.blob_en), 32'd0);
    checkOutput("rst_laser_on", 32'(bus.laser_on), 32'd0);
    checkOutput("rst_round_done", 32'(bus.round_done), 32'd0);
    checkOutput("rst_cur_slot", 32'(bus.cur_slot), 32'd3);
    checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd1);

    // Single point on slot 1
    applyStimulus(2'd1, 10'd100, 10'd200, 9'h1C0, 1'b1);
    commitFrame();
    waitCycles(1);
    checkOutput("single_e1_x", 32'(bus.x_loc), 32'd0);
    waitCycles(1);
    checkOutput("single_e2_x", 32'(bus.x_loc), 32'd100);
    checkOutput("single_e2_y", 32'(bus.y_loc), 32'd200);
    checkOutput("single_e2_color", 32'(bus.color), 32'h1C0);
    checkOutput("single_e2_slot", 32'(bus.cur_slot), 32'd1);
    checkOutput("single_e2_round", 32'(bus.round_done), 32'd1);
    checkOutput("single_e2_blob", 32'(bus.blob_en), 32'd0);
    waitCycles(1);
    checkOutput("single_e3_blob", 32'(bus.blob_en), 32'd0);
    checkOutput("single_e3_round", 32'(bus.round_done), 32'd0);
    waitCycles(1);
    checkOutput("single_e4_blob", 32'(bus.blob_en), 32'd1);
    checkOutput("single_e4_laser", 32'(bus.laser_on), 32'd1);
    onCount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.blob_en === 1'b1) onCount++;
    end
    checkOutput("single_lit_e5_e12", 32'(onCount), 32'd7);
    checkOutput("single_e12_blob", 32'(bus.blob_en), 32'd0);
    waitCycles(1);
    checkOutput("single_e13_round", 32'(bus.round_done), 32'd1);
    checkOutput("single_e13_slot", 32'(bus.cur_slot), 32'd1);
    checkOutput("single_e13_x", 32'(bus.x_loc), 32'd100);

    // Commit blocking and simultaneous write
    doReset();
    applyStimulus(2'd1, 10'd100, 10'd200, 9'h1C0, 1'b1);
    commitFrame();
    waitCycles(3);
    bus.wr_valid   = 1'b1;
    bus.wr_slot    = 2'd1;
    bus.wr_x       = 10'd500;
    bus.wr_y       = 10'd200;
    bus.wr_color   = 9'h1C0;
    bus.wr_enable  = 1'b1;
    bus.frame_sync = 1'b1;
    #1;
    checkOutput("block_ready_commit", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    bus.frame_sync = 1'b0;
    #1;
    checkOutput("block_ready_after", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    waitCycles(8);
    checkOutput("block_old_x", 32'(bus.x_loc), 32'd100);
    checkOutput("block_old_slot", 32'(bus.cur_slot), 32'd1);
    commitFrame();
    waitCycles(10);
    checkOutput("block_new_x", 32'(bus.x_loc), 32'd500);

    // Round-robin with a gap
    doReset();
    applyStimulus(2'd0, 10'd10, 10'd11, 9'h001, 1'b1);
    applyStimulus(2'd2, 10'd30, 10'd31, 9'h003, 1'b1);
    applyStimulus(2'd3, 10'd40, 10'd41, 9'h004, 1'b1);
    commitFrame();
    waitCycles(2);
    checkOutput("rr_v0_slot", 32'(bus.cur_slot), 32'd0);
    checkOutput("rr_v0_x", 32'(bus.x_loc), 32'd10);
    checkOutput("rr_v0_round", 32'(bus.round_done), 32'd1);
    waitCycles(11);
    checkOutput("rr_v1_slot", 32'(bus.cur_slot), 32'd2);
    checkOutput("rr_v1_x", 32'(bus.x_loc), 32'd30);
    checkOutput("rr_v1_round", 32'(bus.round_done), 32'd0);
    waitCycles(11);
    checkOutput("rr_v2_slot", 32'(bus.cur_slot), 32'd3);
    checkOutput("rr_v2_y", 32'(bus.y_loc), 32'd41);
    checkOutput("rr_v2_round", 32'(bus.round_done), 32'd0);
    waitCycles(11);
    checkOutput("rr_v3_slot", 32'(bus.cur_slot), 32'd0);
    checkOutput("rr_v3_round", 32'(bus.round_done), 32'd1);

    // Abort slot 2 during its dwell
    doReset();
    applyStimulus(2'd0, 10'd10, 10'd11, 9'h001, 1'b1);
    applyStimulus(2'd2, 10'd30, 10'd31, 9'h003, 1'b1);
    applyStimulus(2'd3, 10'd40, 10'd41, 9'h004, 1'b1);
    commitFrame();
    waitCycles(17);
    checkOutput("abort_pre_slot", 32'(bus.cur_slot), 32'd2);
    checkOutput("abort_pre_blob", 32'(bus.blob_en), 32'd1);
    applyStimulus(2'd2, 10'd30, 10'd31, 9'h003, 1'b0);
    commitFrame();
    checkOutput("abort_commit_blob", 32'(bus.blob_en), 32'd1);
    waitCycles(1);
    checkOutput("abort_drop_blob", 32'(bus.blob_en), 32'd0);
    checkOutput("abort_drop_laser", 32'(bus.laser_on), 32'd0);
    waitCycles(1);
    checkOutput("abort_next_slot", 32'(bus.cur_slot), 32'd3);
    checkOutput("abort_next_x", 32'(bus.x_loc), 32'd40);
    checkOutput("abort_next_round", 32'(bus.round_done), 32'd0);

    // Mid-visit asynchronous reset during slot 3 dwell
    waitCycles(3);
    checkOutput("mreset_pre_laser", 32'(bus.laser_on), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mreset_async_laser", 32'(bus.laser_on), 32'd0);
    checkOutput("mreset_async_blob", 32'(bus.blob_en), 32'd0);
    checkOutput("mreset_async_slot", 32'(bus.cur_slot), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(15);
    checkOutput("mreset_idle_blob", 32'(bus.blob_en), 32'd0);
    checkOutput("mreset_idle_x", 32'(bus.x_loc), 32'd0);

    // Out-of-range slot on the 3-slot instance
    bus3.wr_valid  = 1'b1;
    bus3.wr_slot   = 2'd3;
    bus3.wr_x      = 10'd7;
    bus3.wr_y      = 10'd8;
    bus3.wr_color  = 9'h0FF;
    bus3.wr_enable = 1'b1;
    @(negedge clk);
    bus3.wr_valid   = 1'b0;
    bus3.frame_sync = 1'b1;
    @(negedge clk);
    bus3.frame_sync = 1'b0;
    waitCycles(4);
    checkOutput("badslot_blob", 32'(bus3.blob_en), 32'd0);
    checkOutput("badslot_x", 32'(bus3.x_loc), 32'd0);
    checkOutput("badslot_slot", 32'(bus3.cur_slot), 32'd2);
    bus3.wr_valid = 1'b1;
    bus3.wr_slot  = 2'd0;
    @(negedge clk);
    bus3.wr_valid   = 1'b0;
    bus3.frame_sync = 1'b1;
    @(negedge clk);
    bus3.frame_sync = 1'b0;
    waitCycles(2);
    checkOutput("goodslot_x", 32'(bus3.x_loc), 32'd7);
    checkOutput("goodslot_slot", 32'(bus3.cur_slot), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
